// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - digit widths, BCD limits and digit-increment helpers for time_keeper
// Purpose: shared constants and pure functions for the BCD time counter chain.
// Contents: field widths, limit constants, minute/hour BCD structs, increment helpers.
package time_pkg;

  localparam int SEC_W       = 6;
  localparam int MIN_ONES_W  = 4;
  localparam int MIN_TENS_W  = 3;
  localparam int HOUR_ONES_W = 4;
  localparam int HOUR_TENS_W = 2;

  localparam logic [SEC_W-1:0]       SEC_MAX            = 6'd59;
  localparam logic [3:0]             DIGIT_MAX          = 4'd9;
  localparam logic [MIN_TENS_W-1:0]  MIN_TENS_MAX       = 3'd5;
  localparam logic [HOUR_TENS_W-1:0] HOUR_TENS_MAX      = 2'd2;
  localparam logic [HOUR_ONES_W-1:0] HOUR_ONES_MAX_AT_2 = 4'd3;

  typedef struct packed {
    logic [MIN_TENS_W-1:0] tens;
    logic [MIN_ONES_W-1:0] ones;
  } min_t;

  typedef struct packed {
    logic [HOUR_TENS_W-1:0] tens;
    logic [HOUR_ONES_W-1:0] ones;
  } hour_t;

  // Out-of-range digits use >= so a forced illegal value wraps to 0 on its next increment.
  function automatic min_t min_inc(input min_t cur);
    min_t nxt;
    if (cur.ones >= DIGIT_MAX) begin
      nxt.ones = '0;
      nxt.tens = (cur.tens >= MIN_TENS_MAX) ? '0 : cur.tens + 1'b1;
    end else begin
      nxt.ones = cur.ones + 1'b1;
      nxt.tens = cur.tens;
    end
    return nxt;
  endfunction

  function automatic logic min_wraps(input min_t cur);
    return (cur.ones >= DIGIT_MAX) && (cur.tens >= MIN_TENS_MAX);
  endfunction

  // 23 -> 00; otherwise ordinary BCD carry from ones into tens.
  function automatic hour_t hour_inc(input hour_t cur);
    hour_t nxt;
    if (((cur.tens >= HOUR_TENS_MAX) && (cur.ones >= HOUR_ONES_MAX_AT_2)) ||
        (cur.tens > HOUR_TENS_MAX)) begin
      nxt = '0;
    end else if (cur.ones >= DIGIT_MAX) begin
      nxt.ones = '0;
      nxt.tens = cur.tens + 1'b1;
    end else begin
      nxt.ones = cur.ones + 1'b1;
      nxt.tens = cur.tens;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - 2-FF synchronizer, stability-counter debouncer and rising-edge pulse
// Purpose: turn a raw asynchronous button into a single-cycle press pulse.
// Ports: clk, rst_n (async, active-low), btn_raw (async, active-high),
//        pulse (one cycle, registered, on each accepted low->high transition).
module debounce #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds how many consecutive earlier cycles the synchronized input has
  // disagreed with the accepted level; any agreeing cycle restarts it.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 1 Hz prescaler and 24-hour BCD clock with debounced set buttons
// Purpose: divide clk to a one-second tick and keep HH:MM:SS (seconds binary, rest BCD).
// Ports: clk, rst_n (async, active-low), btn_hour / btn_min (raw async buttons),
//        sec_tick (one-cycle pulse per second), seconds, min_ones, min_tens,
//        hour_ones, hour_tens (all registered).
module time_keeper
  import time_pkg::*;
#(
  parameter int CLK_HZ          = 12_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_hour,
  input  logic       btn_min,
  output logic       sec_tick,
  output logic [5:0] seconds,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [1:0] hour_tens
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  logic               hour_pulse, min_pulse;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  min_t               min_q, min_d;
  hour_t              hour_q, hour_d;
  logic               sec_tick_q, sec_tick_d;
  logic               hour_carry;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hour (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_hour),
    .pulse   (hour_pulse)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_min),
    .pulse   (min_pulse)
  );

  // A minute press restarts the second, so it swallows a coincident tick.
  // An hour press replaces any tick carry into hours rather than adding to it.
  always_comb begin
    presc_d    = presc_q + 1'b1;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    sec_tick_d = 1'b0;
    hour_carry = 1'b0;
    if (min_pulse) begin
      presc_d = '0;
      sec_d   = '0;
      min_d   = min_inc(min_q);
    end else if (presc_q >= PRESC_LAST) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_q >= SEC_MAX) begin
        sec_d      = '0;
        min_d      = min_inc(min_q);
        hour_carry = min_wraps(min_q);
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
    if (hour_pulse || hour_carry) begin
      hour_d = hour_inc(hour_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign sec_tick  = sec_tick_q;
  assign seconds   = sec_q;
  assign min_ones  = min_q.ones;
  assign min_tens  = min_q.tens;
  assign hour_ones = hour_q.ones;
  assign hour_tens = hour_q.tens;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper against a behavioural clock model
module tb_time_keeper;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_hour = 1'b0;
  logic       btn_min = 1'b0;
  logic       sec_tick;
  logic [5:0] seconds;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hour_ones;
  logic [1:0] hour_tens;

  int vectors = 0;
  int miscompares = 0;

  time_keeper #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_hour  (btn_hour),
    .btn_min   (btn_min),
    .sec_tick  (sec_tick),
    .seconds   (seconds),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .hour_ones (hour_ones),
    .hour_tens (hour_tens)
  );

  always #5 clk = ~clk;

  // Behavioural model: time as plain integers h/m/s, prescaler as an integer,
  // buttons as a history of raw samples (index k = sampled k edges ago).
  int              m_h, m_m, m_s, m_presc;
  bit              m_tick;
  logic [DEB+1:0]  hist_h, hist_m;
  bit              acc_h, acc_m, pend_h, pend_m;

  always @(posedge clk or negedge rst_n) begin : model
    bit hp, mp, carry;
    if (!rst_n) begin
      m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_tick = 0;
      hist_h = '0; hist_m = '0;
      acc_h = 0; acc_m = 0; pend_h = 0; pend_m = 0;
    end else begin
      hp = pend_h;
      mp = pend_m;
      // A press is accepted once the synchronized input (2 edges late) has shown
      // the new level for DEB consecutive edges; its pulse acts one edge later.
      hist_h = {hist_h[DEB:0], btn_hour};
      hist_m = {hist_m[DEB:0], btn_min};
      pend_h = 0;
      pend_m = 0;
      if (!acc_h && (&hist_h[DEB+1:2])) begin acc_h = 1; pend_h = 1; end
      else if (acc_h && !(|hist_h[DEB+1:2])) acc_h = 0;
      if (!acc_m && (&hist_m[DEB+1:2])) begin acc_m = 1; pend_m = 1; end
      else if (acc_m && !(|hist_m[DEB+1:2])) acc_m = 0;

      carry = 0;
      m_tick = 0;
      if (mp) begin
        m_m = (m_m + 1) % 60;
        m_s = 0;
        m_presc = 0;
      end else if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        m_tick = 1;
        m_s = m_s + 1;
        if (m_s == 60) begin
          m_s = 0;
          m_m = m_m + 1;
          if (m_m == 60) begin
            m_m = 0;
            carry = 1;
          end
        end
      end else begin
        m_presc = m_presc + 1;
      end
      if (hp || carry) m_h = (m_h + 1) % 24;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (sec_tick !== m_tick || int'(seconds) != m_s ||
          int'(min_ones) != m_m % 10 || int'(min_tens) != m_m / 10 ||
          int'(hour_ones) != m_h % 10 || int'(hour_tens) != m_h / 10) begin
        miscompares++;
        $display("FAIL model t=%0t: got %0d%0d:%0d%0d:%0d tick=%0b, want %0d:%0d:%0d tick=%0b",
                 $time, hour_tens, hour_ones, min_tens, min_ones, seconds, sec_tick,
                 m_h, m_m, m_s, m_tick);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour_tens"}, int'(hour_tens), h / 10);
    chk({name, ".hour_ones"}, int'(hour_ones), h % 10);
    chk({name, ".min_tens"},  int'(min_tens),  m / 10);
    chk({name, ".min_ones"},  int'(min_ones),  m % 10);
    chk({name, ".seconds"},   int'(seconds),   s);
  endtask

  task automatic press(input bit is_min);
    int hold, gap;
    hold = $urandom_range(5, 9);
    gap  = $urandom_range(8, 11);
    @(negedge clk);
    if (is_min) btn_min = 1'b1; else btn_hour = 1'b1;
    repeat (hold) @(negedge clk);
    btn_min = 1'b0;
    btn_hour = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic hour_to(input int target);
    int n;
    n = 0;
    while (m_h != target && n < 30) begin press(1'b0); n++; end
    if (m_h != target) begin
      vectors++; miscompares++;
      $display("FAIL hour_to: model hour %0d, want %0d after %0d presses", m_h, target, n);
    end
  endtask

  task automatic min_to(input int target);
    int n;
    n = 0;
    while (m_m != target && n < 70) begin press(1'b1); n++; end
    if (m_m != target) begin
      vectors++; miscompares++;
      $display("FAIL min_to: model minute %0d, want %0d after %0d presses", m_m, target, n);
    end
  endtask

  // target_p < 0 means any prescaler phase.
  task automatic wait_sec(input string name, input int target_s, input int target_p);
    int n;
    n = 0;
    while (!(m_s == target_s && (target_p < 0 || m_presc == target_p)) && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1200) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, model s=%0d presc=%0d, want s=%0d presc=%0d",
               name, m_s, m_presc, target_s, target_p);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_time("reset", 0, 0, 0);
    chk("reset.sec_tick", int'(sec_tick), 0);
    rst_n = 1'b1;

    // First tick on edge 10.
    repeat (9) @(negedge clk);
    chk("edge9.sec_tick", int'(sec_tick), 0);
    chk("edge9.seconds", int'(seconds), 0);
    @(negedge clk);
    chk("edge10.sec_tick", int'(sec_tick), 1);
    chk_time("edge10", 0, 0, 1);

    // Minute held 20 cycles: one increment, 7 edges after the raw rise.
    btn_min = 1'b1;
    repeat (6) @(negedge clk);
    chk("min_hold.early", int'(min_ones), 0);
    @(negedge clk);
    chk("min_hold.edge7.min_ones", int'(min_ones), 1);
    chk("min_hold.edge7.seconds", int'(seconds), 0);
    chk("min_hold.edge7.sec_tick", int'(sec_tick), 0);
    repeat (13) @(negedge clk);
    btn_min = 1'b0;
    repeat (12) @(negedge clk);
    chk("min_hold.once", int'(min_ones), 1);

    // Short hour glitch ignored, longer hold accepted.
    btn_hour = 1'b1;
    repeat (3) @(negedge clk);
    btn_hour = 1'b0;
    repeat (15) @(negedge clk);
    chk("hour_glitch", int'(hour_ones), 0);
    btn_hour = 1'b1;
    repeat (10) @(negedge clk);
    btn_hour = 1'b0;
    repeat (10) @(negedge clk);
    chk("hour_hold.ones", int'(hour_ones), 1);
    chk("hour_hold.tens", int'(hour_tens), 0);

    // Hour BCD boundaries.
    hour_to(9);
    chk("h09.ones", int'(hour_ones), 9);
    press(1'b0);
    chk("h09to10.tens", int'(hour_tens), 1);
    chk("h09to10.ones", int'(hour_ones), 0);
    hour_to(19);
    press(1'b0);
    chk("h19to20.tens", int'(hour_tens), 2);
    chk("h19to20.ones", int'(hour_ones), 0);
    hour_to(23);
    press(1'b0);
    chk("h23to00.tens", int'(hour_tens), 0);
    chk("h23to00.ones", int'(hour_ones), 0);

    // Minute wrap by button leaves hours alone, then full-day rollover by tick.
    hour_to(23);
    min_to(59);
    chk("m59.tens", int'(min_tens), 5);
    chk("m59.ones", int'(min_ones), 9);
    press(1'b1);
    chk("m59to00.min_tens", int'(min_tens), 0);
    chk("m59to00.min_ones", int'(min_ones), 0);
    chk("m59to00.hour_tens", int'(hour_tens), 2);
    chk("m59to00.hour_ones", int'(hour_ones), 3);
    min_to(59);
    wait_sec("wait_235959", 59, -1);
    repeat (9) @(negedge clk);
    chk_time("pre_rollover", 23, 59, 59);
    chk("pre_rollover.sec_tick", int'(sec_tick), 0);
    @(negedge clk);
    chk_time("rollover", 0, 0, 0);
    chk("rollover.sec_tick", int'(sec_tick), 1);
    @(negedge clk);
    chk("rollover.single_tick", int'(sec_tick), 0);

    // Minute pulse coincident with the terminal count at 12:34:59.
    hour_to(12);
    min_to(34);
    wait_sec("wait_123459", 59, 3);
    btn_min = 1'b1;
    repeat (7) @(negedge clk);
    chk_time("min_vs_tick", 12, 35, 0);
    chk("min_vs_tick.sec_tick", int'(sec_tick), 0);
    btn_min = 1'b0;
    repeat (10) @(negedge clk);

    // Hour pulse coincident with a tick carrying into hours at 12:59:59.
    min_to(59);
    wait_sec("wait_125959", 59, 3);
    btn_hour = 1'b1;
    repeat (7) @(negedge clk);
    chk_time("hour_vs_tick", 13, 0, 0);
    chk("hour_vs_tick.sec_tick", int'(sec_tick), 1);
    btn_hour = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-count with a press mid-debounce.
    hour_to(5);
    min_to(43);
    wait_sec("wait_054321", 21, -1);
    chk_time("pre_reset", 5, 43, 21);
    btn_hour = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_reset", 0, 0, 0);
    chk("async_reset.sec_tick", int'(sec_tick), 0);
    btn_hour = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk_time("post_reset.edge9", 0, 0, 0);
    chk("post_reset.edge9.sec_tick", int'(sec_tick), 0);
    @(negedge clk);
    chk_time("post_reset.edge10", 0, 0, 1);
    chk("post_reset.edge10.sec_tick", int'(sec_tick), 1);

    // Random button activity, including glitches and simultaneous presses.
    repeat (200) begin
      btn_hour = ($urandom_range(0, 3) == 0);
      btn_min  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    btn_hour = 1'b0;
    btn_min = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
